// File: rtl/pic_ack_if.sv
// Signal bundle between the interrupt-acknowledge sequencer, the PIC read side
// and the CPU core that consumes captured vectors.
interface pic_ack_if;
    logic       enable;
    logic       int_in;
    logic [7:0] data_in;
    logic       intackN;
    logic       busy;
    // A vector transfers on every rising clk edge that samples vec_valid=1 and vec_ready=1.
    // vec_valid stays 1 with vec_num/vec_err frozen until that edge; vec_ready is don't-care otherwise.
    logic       vec_valid;
    logic       vec_ready;
    logic [2:0] vec_num;
    logic       vec_err;
    logic       spurious;

    modport master (
        input  enable, int_in, data_in, vec_ready,
        output intackN, busy, vec_valid, vec_num, vec_err, spurious
    );

    modport slave (
        output enable, int_in, data_in, vec_ready,
        input  intackN, busy, vec_valid, vec_num, vec_err, spurious
    );
endinterface

// File: rtl/pic_ack_sequencer.sv
// CPU-side interrupt acknowledge engine: two intackN pulses per interrupt, vector
// captured on the second pulse and held in a one-entry buffer for the CPU core.
module pic_ack_sequencer #(
    parameter int unsigned ACK_LOW_CYCLES = 2,
    parameter int unsigned ACK_GAP_CYCLES = 2,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter logic [4:0]  VEC_PREFIX     = 5'b10100
) (
    input  logic       clk,
    input  logic       resetN,
    pic_ack_if.master  bus,
    output logic [2:0] dbg_state
);
    localparam int unsigned MAX_LG  = (ACK_LOW_CYCLES > ACK_GAP_CYCLES) ? ACK_LOW_CYCLES : ACK_GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_LG > RECOVER_CYCLES) ? MAX_LG : RECOVER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(ACK_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(ACK_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACK1_LOW = 3'd1,
        S_ACK1_GAP = 3'd2,
        S_ACK2_LOW = 3'd3,
        S_RECOVER  = 3'd4,
        S_HOLD     = 3'd5
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             intackN_q,   intackN_d;
    logic             busy_q,      busy_d;
    logic             vec_valid_q, vec_valid_d;
    logic [2:0]       vec_num_q,   vec_num_d;
    logic             vec_err_q,   vec_err_d;
    logic             spurious_q,  spurious_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        intackN_d   = intackN_q;
        vec_valid_d = vec_valid_q;
        vec_num_d   = vec_num_q;
        vec_err_d   = vec_err_q;
        spurious_d  = 1'b0;

        if (vec_valid_q && bus.vec_ready) begin
            vec_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.enable && bus.int_in && !vec_valid_q) begin
                    state_d   = S_ACK1_LOW;
                    cnt_d     = '0;
                    intackN_d = 1'b0;
                end
            end
            S_ACK1_LOW: begin
                if (!bus.int_in) begin
                    state_d    = S_RECOVER;
                    cnt_d      = '0;
                    intackN_d  = 1'b1;
                    spurious_d = 1'b1;
                end else if (cnt_q == LOW_LAST) begin
                    state_d   = S_ACK1_GAP;
                    cnt_d     = '0;
                    intackN_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ACK1_GAP: begin
                if (!bus.int_in) begin
                    state_d    = S_RECOVER;
                    cnt_d      = '0;
                    intackN_d  = 1'b1;
                    spurious_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d   = S_ACK2_LOW;
                    cnt_d     = '0;
                    intackN_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // PIC is committed once pulse 2 starts, so int_in is no longer consulted.
            S_ACK2_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    state_d     = S_RECOVER;
                    cnt_d       = '0;
                    intackN_d   = 1'b1;
                    vec_valid_d = 1'b1;
                    vec_num_d   = bus.data_in[2:0];
                    vec_err_d   = (bus.data_in[7:3] != VEC_PREFIX);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d   = '0;
                    state_d = vec_valid_d ? S_HOLD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Leaving on the consuming edge lets the next sequence start one cycle after vec_valid falls.
            S_HOLD: begin
                if (!vec_valid_d) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                intackN_d = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            intackN_q   <= 1'b1;
            busy_q      <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_num_q   <= 3'd0;
            vec_err_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            intackN_q   <= intackN_d;
            busy_q      <= busy_d;
            vec_valid_q <= vec_valid_d;
            vec_num_q   <= vec_num_d;
            vec_err_q   <= vec_err_d;
            spurious_q  <= spurious_d;
        end
    end

    assign bus.intackN   = intackN_q;
    assign bus.busy      = busy_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec_num   = vec_num_q;
    assign bus.vec_err   = vec_err_q;
    assign bus.spurious  = spurious_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Bench for pic_ack_sequencer: directed scenarios plus randomized sequences
// checked against a cycle-timeline model derived from the parameter values.
module tb_pic_ack_sequencer;
    localparam int         A   = 2;
    localparam int         G   = 2;
    localparam int         R   = 2;
    localparam logic [4:0] PFX = 5'b10100;
    localparam int         V   = 2*A + G + 1;

    logic       clk = 1'b0;
    logic       resetN;
    logic [2:0] dbg_state;

    pic_ack_if bus ();

    pic_ack_sequencer #(
        .ACK_LOW_CYCLES (A),
        .ACK_GAP_CYCLES (G),
        .RECOVER_CYCLES (R),
        .VEC_PREFIX     (PFX)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_mis = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] vec_of(input logic [7:0] d);
        return {d[7:3] != PFX, d[2:0]};
    endfunction

    function automatic logic [2:0] pic_idx(input logic [7:0] irr);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (irr[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Cycle 0 is the cycle int_in is first seen high in IDLE; drop_d>0 lowers int_in in that cycle.
    task automatic run_seq(input logic [7:0] data, input int drop_d, input int rdly);
        int         c, e, low_end;
        logic       exp_low, exp_valid;
        logic [3:0] want;
        c = V + rdly;
        if (drop_d > 0) e = drop_d + R + 1;
        else            e = (V + R > c + 1) ? V + R : c + 1;
        low_end = (drop_d < A) ? drop_d : A;
        for (int k = 0; k <= e + 1; k++) begin
            if (drop_d > 0) exp_low = (k >= 1 && k <= low_end);
            else            exp_low = (k >= 1 && k <= A) || (k >= A+G+1 && k <= 2*A+G);
            exp_valid = (drop_d == 0) && (k >= V) && (k <= c);
            check($sformatf("intackN@%0d", k),   bus.intackN,   !exp_low);
            check($sformatf("spurious@%0d", k),  bus.spurious,  (drop_d > 0) && (k == drop_d + 1));
            check($sformatf("busy@%0d", k),      bus.busy,      (k >= 1) && (k < e));
            check($sformatf("vec_valid@%0d", k), bus.vec_valid, exp_valid);
            if (exp_valid) check($sformatf("vec@%0d", k), {bus.vec_err, bus.vec_num}, vec_of(data));

            bus.enable = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (drop_d > 0)    bus.int_in = (k < drop_d);
            else if (k <= A+G) bus.int_in = 1'b1;
            else if (k < e)    bus.int_in = 1'($urandom_range(0, 1));
            else               bus.int_in = 1'b0;
            bus.data_in = (k == 2*A+G) ? data : 8'($urandom);
            if (drop_d == 0 && k == c) bus.vec_ready = 1'b1;
            else if (exp_valid)        bus.vec_ready = 1'b0;
            else                       bus.vec_ready = 1'($urandom_range(0, 1));

            if (drop_d == 0 && k == 2*A+G) exp_q.push_back(vec_of(data));
            if (drop_d == 0 && k == c) begin
                want = exp_q.pop_front();
                check("sb_vector", {bus.vec_err, bus.vec_num}, want);
            end
            cycle();
        end
    endtask

    initial begin
        int         low_cnt, pulses;
        logic       prev_ack;
        logic [7:0] irr, pdata, rdata;
        logic [3:0] seen_vec, pic_vec;
        int         drop, rdly;

        // Reset state
        resetN = 1'b0;
        bus.enable = 1'b0; bus.int_in = 1'b0; bus.data_in = 8'h00; bus.vec_ready = 1'b0;
        repeat (3) cycle();
        check("rst_intackN",   bus.intackN,   1'b1);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_vec_valid", bus.vec_valid, 1'b0);
        check("rst_vec_num",   bus.vec_num,   3'd0);
        check("rst_vec_err",   bus.vec_err,   1'b0);
        check("rst_spurious",  bus.spurious,  1'b0);
        check("rst_state",     dbg_state,     3'd0);
        resetN = 1'b1;
        cycle();

        // T1, T2, T3
        run_seq(8'hA5, 0, 2);
        run_seq(8'h33, 0, 1);
        run_seq(8'hA1, 3, 0);

        // T4: vector held unconsumed with int_in continuously high
        bus.enable = 1'b1; bus.int_in = 1'b1; bus.vec_ready = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < V + 20; k++) begin
            if (bus.intackN === 1'b0) low_cnt++;
            if (k >= V) check($sformatf("t4_hold@%0d", k), {bus.vec_valid, bus.vec_err, bus.vec_num}, {1'b1, vec_of(8'hA2)});
            bus.data_in = (k == 2*A+G) ? 8'hA2 : 8'h5F;
            cycle();
        end
        check("t4_valid_before_ready", bus.vec_valid, 1'b1);
        bus.vec_ready = 1'b1;
        cycle();
        if (bus.intackN === 1'b0) low_cnt++;
        check("t4_valid_drop", bus.vec_valid, 1'b0);
        check("t4_low_cycles", low_cnt, 2*A);
        bus.vec_ready = 1'b0;
        cycle();
        check("t4_restart", bus.intackN, 1'b0);

        // T5: reset while in the second pulse
        repeat (A + G) cycle();
        check("t5_in_ack2", bus.intackN, 1'b0);
        resetN = 1'b0;
        #1;
        check("t5_intackN", bus.intackN,   1'b1);
        check("t5_valid",   bus.vec_valid, 1'b0);
        check("t5_busy",    bus.busy,      1'b0);
        cycle();
        resetN = 1'b1;
        run_seq(8'hA6, 0, 0);

        // T6: simple PIC model raises int_out from its request register
        irr = 8'h10; pulses = 0; prev_ack = 1'b1; seen_vec = 4'hF; pic_vec = 4'h0;
        bus.enable = 1'b1; bus.vec_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (prev_ack && !bus.intackN) pulses++;
            if (!prev_ack && bus.intackN && pulses == 2 && irr != 8'h00) irr = irr & ~(8'h01 << pic_idx(irr));
            prev_ack = bus.intackN;
            if (bus.vec_valid) seen_vec = {bus.vec_err, bus.vec_num};
            bus.int_in = |irr;
            if (!bus.intackN && pulses == 2 && irr != 8'h00) begin
                pdata = {PFX, pic_idx(irr)};
                pic_vec = vec_of(pdata);
            end else begin
                pdata = 8'hFF;
            end
            bus.data_in = pdata;
            cycle();
        end
        check("t6_pulses",  pulses,   2);
        check("t6_vector",  seen_vec, pic_vec);
        check("t6_intackN", bus.intackN, 1'b1);
        check("t6_busy",    bus.busy,    1'b0);
        check("t6_valid",   bus.vec_valid, 1'b0);

        // enable low gates new starts
        bus.enable = 1'b0; bus.int_in = 1'b1; bus.vec_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check($sformatf("gate_busy@%0d", k),    bus.busy,    1'b0);
            check($sformatf("gate_intackN@%0d", k), bus.intackN, 1'b1);
        end
        bus.int_in = 1'b0;
        cycle();

        // Randomized sequences
        for (int it = 0; it < 24; it++) begin
            rdata = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rdata[7:3] = PFX;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, A + G) : 0;
            rdly = ($urandom_range(0, 4) == 0) ? $urandom_range(7, 25) : $urandom_range(0, 6);
            run_seq(rdata, drop, rdly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
